// File: rtl/des_key_schedule_if.sv
// Key-schedule request/result bundle: key request in, 16 packed round keys out.
interface des_key_schedule_if;
    logic         start;
    logic [63:0]  key;
    logic         decrypt;
    logic         busy;
    logic         keys_valid;
    logic [767:0] round_keys;

    modport master (
        output start,
        output key,
        output decrypt,
        input  busy,
        input  keys_valid,
        input  round_keys
    );

    modport slave (
        input  start,
        input  key,
        input  decrypt,
        output busy,
        output keys_valid,
        output round_keys
    );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one 48-bit round key per cycle, written into a
// 768-bit bus (slot 1 at the MSB end), optionally in reversed (decrypt) order.
module des_key_schedule (
    input  logic                clk,
    input  logic                rst,
    des_key_schedule_if.slave   ks
);

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 56;
    localparam int unsigned HALF_W   = 28;
    localparam int unsigned SUBKEY_W = 48;
    localparam int unsigned ROUNDS   = 16;
    localparam int unsigned RK_W     = SUBKEY_W * ROUNDS;
    localparam int unsigned CNT_W    = 5;

    // Key bit (1 = MSB) feeding each PC-1 output position, first entry = C bit 1.
    localparam int unsigned PC1_TBL [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // CD bit (1 = MSB of C) feeding each round-key position, first entry = key bit 1.
    localparam int unsigned PC2_TBL [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // PC-1: 64-bit key (parity bits dropped) to 56-bit {C,D}.
    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CD_W); i++) begin
            r[6'(int'(CD_W) - 1 - i)] = k[6'(KEY_W - PC1_TBL[i])];
        end
        return r;
    endfunction

    // PC-2: rotated 56-bit {C,D} to 48-bit round key.
    function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SUBKEY_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(SUBKEY_W); i++) begin
            r[6'(int'(SUBKEY_W) - 1 - i)] = cd[6'(CD_W - PC2_TBL[i])];
        end
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [HALF_W-1:0]   c_q, c_d;
    logic [HALF_W-1:0]   d_q, d_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dec_q, dec_d;
    logic [RK_W-1:0]     rk_q, rk_d;
    logic                busy_q, busy_d;
    logic                kv_q, kv_d;

    logic                shift_one;
    logic [HALF_W-1:0]   c_rot, d_rot;
    logic [SUBKEY_W-1:0] subkey;
    logic [CNT_W-1:0]    slot;
    logic [9:0]          slot_base;

    // State and datapath registers; reset clears everything including the key bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            rk_q    <= '0;
            busy_q  <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            rk_q    <= rk_d;
            busy_q  <= busy_d;
            kv_q    <= kv_d;
        end
    end

    // Next-state logic: accept start in IDLE/DONE, one rotation + PC-2 per GEN cycle.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        dec_d     = dec_q;
        rk_d      = rk_q;

        shift_one = (cnt_q == CNT_W'(1)) || (cnt_q == CNT_W'(2)) ||
                    (cnt_q == CNT_W'(9)) || (cnt_q == CNT_W'(16));
        c_rot     = shift_one ? {c_q[HALF_W-2:0], c_q[HALF_W-1]}
                              : {c_q[HALF_W-3:0], c_q[HALF_W-1:HALF_W-2]};
        d_rot     = shift_one ? {d_q[HALF_W-2:0], d_q[HALF_W-1]}
                              : {d_q[HALF_W-3:0], d_q[HALF_W-1:HALF_W-2]};
        subkey    = pc2({c_rot, d_rot});
        slot      = dec_q ? (CNT_W'(ROUNDS + 1) - cnt_q) : cnt_q;
        slot_base = 10'(RK_W - SUBKEY_W * 32'(slot));

        case (state_q)
            IDLE, DONE: begin
                if (ks.start) begin
                    {c_d, d_d} = pc1(ks.key);
                    dec_d      = ks.decrypt;
                    cnt_d      = CNT_W'(1);
                    state_d    = GEN;
                end
            end
            GEN: begin
                c_d                        = c_rot;
                d_d                        = d_rot;
                rk_d[slot_base +: SUBKEY_W] = subkey;
                if (cnt_q == CNT_W'(ROUNDS)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == GEN);
        kv_d   = (state_d == DONE);
    end

    assign ks.busy       = busy_q;
    assign ks.keys_valid = kv_q;
    assign ks.round_keys = rk_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed + random bench for des_key_schedule against a closed-form schedule model.
module tb_des_key_schedule;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    des_key_schedule_if ks_if ();

    des_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .ks  (ks_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Reference: round n uses C0/D0 rotated by the cumulative shift count, bits 1-indexed MSB-first.
    function automatic logic [767:0] model_sched(input logic [63:0] key, input bit dec);
        bit          kb [1:64];
        bit          cd0 [1:56];
        bit          cdn [1:56];
        logic [767:0] rk;
        int          s;
        int          slot;
        int          p;
        rk = '0;
        for (int i = 1; i <= 64; i++) kb[i] = key[64 - i];
        for (int j = 1; j <= 56; j++) cd0[j] = kb[PC1[j - 1]];
        s = 0;
        for (int n = 1; n <= 16; n++) begin
            s += SHIFTS[n - 1];
            for (int j = 1; j <= 28; j++) begin
                cdn[j]      = cd0[((j - 1 + s) % 28) + 1];
                cdn[28 + j] = cd0[28 + ((j - 1 + s) % 28) + 1];
            end
            slot = dec ? (17 - n) : n;
            for (int m = 1; m <= 48; m++) begin
                p = 48 * (slot - 1) + m;
                rk[768 - p] = cdn[PC2[m - 1]];
            end
        end
        return rk;
    endfunction

    task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Pulse start for one edge; key/decrypt are scrambled afterwards to prove they were latched.
    task automatic do_start(input logic [63:0] k, input bit d);
        @(negedge clk);
        ks_if.start   = 1'b1;
        ks_if.key     = k;
        ks_if.decrypt = d;
        @(negedge clk);
        ks_if.start   = 1'b0;
        ks_if.key     = {$urandom, $urandom};
        ks_if.decrypt = ~d;
    endtask

    // Start a schedule and check busy/keys_valid at every edge through completion.
    task automatic run_timed(input string tag, input logic [63:0] k, input bit d);
        do_start(k, d);
        for (int e = 0; e <= 16; e++) begin
            check({tag, "_busy"}, 768'(ks_if.busy), 768'(e < 16));
            check({tag, "_kv"}, 768'(ks_if.keys_valid), 768'(e == 16));
            if (e < 16) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!ks_if.keys_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 768'(ks_if.keys_valid), 768'(1));
    endtask

    initial begin
        logic [767:0] rk;
        logic [767:0] exp_a;
        logic [63:0]  key_a;
        logic [63:0]  rkey;
        bit           rdec;

        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        ks_if.start   = 1'b0;
        ks_if.key     = '0;
        ks_if.decrypt = 1'b0;

        // Reset state
        #12;
        check("rst_busy", 768'(ks_if.busy), 768'(0));
        check("rst_kv", 768'(ks_if.keys_valid), 768'(0));
        check("rst_rk", ks_if.round_keys, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 768'(ks_if.busy), 768'(0));

        // FIPS example key, encryption order
        key_a = 64'h133457799BBCDFF1;
        run_timed("fips_enc", key_a, 1'b0);
        rk = ks_if.round_keys;
        check("fips_enc_slot1", 768'(rk[767:720]), 768'(48'h1B02EFFC7072));
        check("fips_enc_slot16", 768'(rk[47:0]), 768'(48'hCB3D8B0E17F5));
        check("fips_enc_all", rk, model_sched(key_a, 1'b0));
        repeat (3) @(negedge clk);
        check("fips_enc_hold", ks_if.round_keys, rk);
        check("fips_enc_hold_kv", 768'(ks_if.keys_valid), 768'(1));

        // Same key, decryption order
        run_timed("fips_dec", key_a, 1'b1);
        rk = ks_if.round_keys;
        check("fips_dec_slot1", 768'(rk[767:720]), 768'(48'hCB3D8B0E17F5));
        check("fips_dec_slot16", 768'(rk[47:0]), 768'(48'h1B02EFFC7072));
        check("fips_dec_all", rk, model_sched(key_a, 1'b1));

        // All-zero key and parity-only key give an all-zero schedule
        run_timed("zero_key", 64'h0, 1'b0);
        check("zero_key_rk", ks_if.round_keys, '0);
        run_timed("parity_key", 64'h0101010101010101, 1'b1);
        check("parity_key_rk", ks_if.round_keys, '0);

        // start during GEN is ignored
        key_a = 64'h0E329232EA6D0D73;
        exp_a = model_sched(key_a, 1'b0);
        do_start(key_a, 1'b0);
        for (int e = 0; e <= 16; e++) begin
            if (e == 4 || e == 9) begin
                ks_if.start   = 1'b1;
                ks_if.key     = 64'hFEDCBA9876543210;
                ks_if.decrypt = 1'b1;
            end else begin
                ks_if.start = 1'b0;
            end
            check("ign_kv", 768'(ks_if.keys_valid), 768'(e == 16));
            if (e < 16) @(negedge clk);
        end
        ks_if.start = 1'b0;
        check("ign_rk", ks_if.round_keys, exp_a);

        // Async reset in the middle of GEN, then a fresh schedule
        do_start(64'hAABB09182736CCDD, 1'b0);
        repeat (7) @(negedge clk);
        check("mid_busy_pre", 768'(ks_if.busy), 768'(1));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy", 768'(ks_if.busy), 768'(0));
        check("mid_rst_kv", 768'(ks_if.keys_valid), 768'(0));
        check("mid_rst_rk", ks_if.round_keys, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_kv", 768'(ks_if.keys_valid), 768'(0));
        run_timed("post_rst", 64'hAABB09182736CCDD, 1'b1);
        check("post_rst_rk", ks_if.round_keys, model_sched(64'hAABB09182736CCDD, 1'b1));

        // Back-to-back from DONE (run_timed checks keys_valid drops after the start edge)
        run_timed("b2b", 64'h3B3898371520F75E, 1'b0);
        check("b2b_rk", ks_if.round_keys, model_sched(64'h3B3898371520F75E, 1'b0));

        // Random keys chained back-to-back
        for (int t = 0; t < 1000; t++) begin
            rkey = {$urandom, $urandom};
            rdec = 1'($urandom_range(0, 1));
            do_start(rkey, rdec);
            check("rnd_kv_low", 768'(ks_if.keys_valid), 768'(0));
            wait_valid("rnd");
            check("rnd_rk", ks_if.round_keys, model_sched(rkey, rdec));
            check("rnd_busy_done", 768'(ks_if.busy), 768'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
